// File: rtl/udp_tx_fifo_reader.sv
// udp_tx_fifo_reader
// Read-side controller for the UDP TX data FIFO. Once a full packet of 32-bit
// words is buffered it sends a start pulse and byte count to the UDP TX engine.
// It then drains exactly that many words, one per engine tx_req.
// Optional build macro UDP_TX_TIMEOUT_FLUSH_EN: if a partial packet sits idle
// for TIMEOUT_CYCLES, it is flushed as a short packet.
module udp_tx_fifo_reader #(
  parameter int PKT_WORDS      = 256,
  parameter int LEVEL_WIDTH    = 11,
  parameter int BYTE_NUM_WIDTH = 16,
  parameter int IFG_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst_n,
  input  logic                      enable,
  output logic                      fifo_rd_en,
  input  logic [31:0]               fifo_rd_data,
  input  logic                      fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0]    fifo_rd_water_level,
  output logic                      tx_start_en,
  output logic [BYTE_NUM_WIDTH-1:0] tx_byte_num,
  input  logic                      tx_req,
  output logic [31:0]               tx_data,
  input  logic                      udp_tx_done,
  output logic                      busy,
  output logic                      underrun,
  output logic [31:0]               pkt_cnt
);

  localparam logic [LEVEL_WIDTH-1:0] PKT_LEVEL  = LEVEL_WIDTH'(PKT_WORDS);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_ZERO = {LEVEL_WIDTH{1'b0}};
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE  = {{(LEVEL_WIDTH-1){1'b0}}, 1'b1};
  localparam int GAP_WIDTH = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_WIDTH-1:0] GAP_LOAD = GAP_WIDTH'(IFG_CYCLES - 1);
  localparam logic [GAP_WIDTH-1:0] GAP_ZERO = {GAP_WIDTH{1'b0}};
  localparam logic [GAP_WIDTH-1:0] GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_SEND      = 3'd2,
    ST_DONE_WAIT = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  state_t                    state_r, state_next_s;
  logic [LEVEL_WIDTH-1:0]    len_r, start_len_s, words_left_r;
  logic [LEVEL_WIDTH+1:0]    bytes_s;
  logic [GAP_WIDTH-1:0]      gap_cnt_r;
  logic                      start_pkt_s, slot_s, last_slot_s, count_pkt_s, early_done_s;
  logic                      full_ready_s, flush_ready_s;
  logic                      slot_d_r, rd_d_r;
  logic [31:0]               tx_data_r, pkt_cnt_r;
  logic [BYTE_NUM_WIDTH-1:0] tx_byte_num_r;
  logic                      tx_start_en_r, busy_r, underrun_r;

  assign full_ready_s = enable && (fifo_rd_water_level >= PKT_LEVEL);

`ifdef UDP_TX_TIMEOUT_FLUSH_EN
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TIMER_WIDTH-1:0] idle_timer_r;
  logic                   partial_s;

  assign partial_s     = enable && (fifo_rd_water_level != LEVEL_ZERO) &&
                         (fifo_rd_water_level < PKT_LEVEL);
  assign flush_ready_s = (state_r == ST_IDLE) && partial_s && (idle_timer_r == TIMER_LAST);

  // Idle timer: runs only while a partial packet waits in IDLE
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      idle_timer_r <= {TIMER_WIDTH{1'b0}};
    end else if ((state_r == ST_IDLE) && partial_s && !flush_ready_s) begin
      idle_timer_r <= idle_timer_r + TIMER_ONE;
    end else begin
      idle_timer_r <= {TIMER_WIDTH{1'b0}};
    end
  end
`else
  // Partial flush is compiled out; only a nonsensical negative timeout could enable it.
  assign flush_ready_s = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

  // Next-state and per-cycle control decode
  always_comb begin
    state_next_s = state_r;
    start_pkt_s  = 1'b0;
    start_len_s  = len_r;
    slot_s       = 1'b0;
    last_slot_s  = 1'b0;
    count_pkt_s  = 1'b0;
    early_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (full_ready_s) begin
          start_pkt_s  = 1'b1;
          start_len_s  = PKT_LEVEL;
          state_next_s = ST_ARM;
        end else if (flush_ready_s) begin
          start_pkt_s  = 1'b1;
          start_len_s  = fifo_rd_water_level;
          state_next_s = ST_ARM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        state_next_s = ST_SEND;
      end
      ST_SEND: begin
        slot_s      = tx_req && (words_left_r != LEVEL_ZERO);
        last_slot_s = slot_s && (words_left_r == LEVEL_ONE);
        if (udp_tx_done) begin
          state_next_s = ST_GAP;
          if (last_slot_s) begin
            count_pkt_s = 1'b1;
          end else begin
            early_done_s = 1'b1;
          end
        end else if (last_slot_s) begin
          state_next_s = ST_DONE_WAIT;
        end else begin
          state_next_s = ST_SEND;
        end
      end
      ST_DONE_WAIT: begin
        if (udp_tx_done) begin
          count_pkt_s  = 1'b1;
          state_next_s = ST_GAP;
        end else begin
          state_next_s = ST_DONE_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_ZERO) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_GAP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FIFO read is combinational so the word lands exactly one cycle later
  assign fifo_rd_en = slot_s && !fifo_rd_empty;
  assign bytes_s    = {start_len_s, 2'b00};

  // State register plus registered status decoded from the next state
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      tx_start_en_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      busy_r        <= (state_next_s != ST_IDLE);
      tx_start_en_r <= (state_next_s == ST_ARM);
    end
  end

  // Packet length, byte count (valid alongside the start pulse) and word countdown
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      len_r         <= LEVEL_ZERO;
      tx_byte_num_r <= {BYTE_NUM_WIDTH{1'b0}};
      words_left_r  <= LEVEL_ZERO;
    end else begin
      if (start_pkt_s) begin
        len_r         <= start_len_s;
        tx_byte_num_r <= BYTE_NUM_WIDTH'(bytes_s);
      end
      if (state_r == ST_ARM) begin
        words_left_r <= len_r;
      end else if (slot_s) begin
        words_left_r <= words_left_r - LEVEL_ONE;
      end
    end
  end

  // Inter-frame gap counter, loaded on entry to GAP
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      gap_cnt_r <= GAP_ZERO;
    end else if ((state_next_s == ST_GAP) && (state_r != ST_GAP)) begin
      gap_cnt_r <= GAP_LOAD;
    end else if ((state_r == ST_GAP) && (gap_cnt_r != GAP_ZERO)) begin
      gap_cnt_r <= gap_cnt_r - GAP_ONE;
    end
  end

  // Packet counter and sticky underrun flag
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pkt_cnt_r  <= 32'd0;
      underrun_r <= 1'b0;
    end else begin
      if (count_pkt_s) begin
        pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end
      if ((slot_s && fifo_rd_empty) || early_done_s) begin
        underrun_r <= 1'b1;
      end
    end
  end

  // Data pipeline: slot -> FIFO data next cycle -> tx_data (zero for a starved slot)
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      slot_d_r  <= 1'b0;
      rd_d_r    <= 1'b0;
      tx_data_r <= 32'd0;
    end else begin
      slot_d_r <= slot_s;
      rd_d_r   <= fifo_rd_en;
      if (slot_d_r) begin
        tx_data_r <= rd_d_r ? fifo_rd_data : 32'd0;
      end
    end
  end

  assign tx_start_en = tx_start_en_r;
  assign tx_byte_num = tx_byte_num_r;
  assign tx_data     = tx_data_r;
  assign busy        = busy_r;
  assign underrun    = underrun_r;
  assign pkt_cnt     = pkt_cnt_r;

endmodule

// File: tb/tb_udp_tx_fifo_reader.sv
// Bench for udp_tx_fifo_reader: behavioural FIFO plus a word-queue reference
// model of what the engine should receive, with randomized data and tx_req gaps.
module tb_udp_tx_fifo_reader;

  localparam int PKT_WORDS      = 256;
  localparam int LEVEL_WIDTH    = 11;
  localparam int BYTE_NUM_WIDTH = 16;
  localparam int IFG_CYCLES     = 16;
  localparam int TIMEOUT_CYCLES = 100;

  logic                      rd_clk = 1'b0;
  logic                      rd_rst_n = 1'b0;
  logic                      enable = 1'b0;
  logic                      fifo_rd_en;
  logic [31:0]               fifo_rd_data = 32'd0;
  logic                      fifo_rd_empty;
  logic [LEVEL_WIDTH-1:0]    fifo_rd_water_level;
  logic                      tx_start_en;
  logic [BYTE_NUM_WIDTH-1:0] tx_byte_num;
  logic                      tx_req = 1'b0;
  logic [31:0]               tx_data;
  logic                      udp_tx_done = 1'b0;
  logic                      busy;
  logic                      underrun;
  logic [31:0]               pkt_cnt;

  int pass_cnt = 0;
  int check_cnt = 0;

  udp_tx_fifo_reader #(
    .PKT_WORDS(PKT_WORDS), .LEVEL_WIDTH(LEVEL_WIDTH), .BYTE_NUM_WIDTH(BYTE_NUM_WIDTH),
    .IFG_CYCLES(IFG_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .udp_tx_done(udp_tx_done), .busy(busy), .underrun(underrun), .pkt_cnt(pkt_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // Behavioural FIFO: data appears one cycle after a read enable
  logic [31:0] mem [0:4095];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  bit  force_lvl = 1'b0;
  int  forced_level = 0;
  assign fifo_rd_empty = (wr_ptr == rd_ptr);
  assign fifo_rd_water_level = force_lvl ? LEVEL_WIDTH'(forced_level) : LEVEL_WIDTH'(wr_ptr - rd_ptr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_rd_data <= mem[rd_ptr % 4096];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Event monitors
  int start_cnt = 0;
  int rden_cnt = 0;
  always @(posedge rd_clk) begin
    if (tx_start_en === 1'b1) start_cnt <= start_cnt + 1;
    if (fifo_rd_en === 1'b1) rden_cnt <= rden_cnt + 1;
  end

  // Reference model: words the engine should receive, in order
  logic [31:0] model_q[$];
  int exp_pkt = 0;
  bit exp_underrun = 1'b0;

  task automatic load_words(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      mem[wr_ptr % 4096] = w;
      model_q.push_back(w);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic wait_start(input int len);
    int t = 0;
    while (tx_start_en !== 1'b1 && t < 400) begin
      @(negedge rd_clk);
      t++;
    end
    check_cnt++;
    if (tx_start_en !== 1'b1) $display("FAIL start_seen: tx_start_en=%b required 1", tx_start_en);
    else pass_cnt++;
    check_cnt++;
    if (tx_byte_num !== BYTE_NUM_WIDTH'(len * 4))
      $display("FAIL byte_num: got %0d required %0d", tx_byte_num, len * 4);
    else pass_cnt++;
    @(negedge rd_clk);
    check_cnt++;
    if ({tx_start_en, busy} !== 2'b01)
      $display("FAIL start_pulse: start/busy=%b required 01", {tx_start_en, busy});
    else pass_cnt++;
  endtask

  task automatic drain(input int len, input bit gaps);
    bit v1 = 1'b0, v2 = 1'b0;
    logic [31:0] e1 = 32'd0, e2 = 32'd0;
    int sent = 0, iter = 0, exp_reads = 0, r0;
    r0 = rden_cnt;
    while ((sent < len || v1 || v2) && iter < len * 8 + 100) begin
      if (v2) begin
        check_cnt++;
        if (tx_data !== e2) $display("FAIL tx_data: got %08h required %08h", tx_data, e2);
        else pass_cnt++;
      end
      v2 = v1;
      e2 = e1;
      if (sent < len && (!gaps || $urandom_range(0, 3) != 0)) begin
        tx_req = 1'b1;
        v1 = 1'b1;
        if (model_q.size() > 0) begin
          e1 = model_q.pop_front();
          exp_reads++;
        end else begin
          e1 = 32'd0;
          exp_underrun = 1'b1;
        end
        sent++;
      end else begin
        tx_req = 1'b0;
        v1 = 1'b0;
      end
      @(negedge rd_clk);
      iter++;
    end
    tx_req = 1'b0;
    check_cnt++;
    if (sent != len) $display("FAIL drain_bound: sent %0d required %0d", sent, len);
    else pass_cnt++;
    check_cnt++;
    if (rden_cnt - r0 != exp_reads) $display("FAIL rd_en_count: got %0d required %0d", rden_cnt - r0, exp_reads);
    else pass_cnt++;
    check_cnt++;
    if (underrun !== exp_underrun) $display("FAIL underrun: got %b required %b", underrun, exp_underrun);
    else pass_cnt++;
    check_cnt++;
    if (pkt_cnt !== exp_pkt || busy !== 1'b1)
      $display("FAIL pre_done: pkt_cnt=%0d busy=%b required %0d/1", pkt_cnt, busy, exp_pkt);
    else pass_cnt++;
  endtask

  task automatic finish_packet();
    int g = 0;
    udp_tx_done = 1'b1;
    @(negedge rd_clk);
    udp_tx_done = 1'b0;
    exp_pkt++;
    check_cnt++;
    if (pkt_cnt !== exp_pkt) $display("FAIL pkt_cnt: got %0d required %0d", pkt_cnt, exp_pkt);
    else pass_cnt++;
    while (busy === 1'b1 && g < 200) begin
      g++;
      @(negedge rd_clk);
    end
    check_cnt++;
    if (g != IFG_CYCLES) $display("FAIL gap_len: got %0d required %0d", g, IFG_CYCLES);
    else pass_cnt++;
  endtask

  task automatic run_packet(input int len, input bit gaps);
    wait_start(len);
    drain(len, gaps);
    finish_packet();
  endtask

  task automatic test_reset();
    rd_rst_n = 1'b0;
    enable = 1'b1;
    tx_req = 1'b1;
    udp_tx_done = 1'b1;
    force_lvl = 1'b1;
    forced_level = 300;
    repeat (3) @(negedge rd_clk);
    check_cnt++;
    if ({fifo_rd_en, tx_start_en, tx_byte_num, tx_data, busy, underrun, pkt_cnt} !== 84'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {fifo_rd_en, tx_start_en, tx_byte_num, tx_data, busy, underrun, pkt_cnt});
    else pass_cnt++;
    force_lvl = 1'b0;
    udp_tx_done = 1'b0;
    rd_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_req = 1'(($urandom) & 32'd1);
      @(negedge rd_clk);
    end
    tx_req = 1'b0;
    check_cnt++;
    if (start_cnt != 0 || rden_cnt != 0 || busy !== 1'b0)
      $display("FAIL idle_empty: starts=%0d reads=%0d busy=%b required 0/0/0", start_cnt, rden_cnt, busy);
    else pass_cnt++;
  endtask

  task automatic test_single_packet();
    int s0 = start_cnt;
    load_words(256);
    run_packet(256, 1'b0);
    check_cnt++;
    if (start_cnt - s0 != 1 || fifo_rd_water_level !== 11'd0)
      $display("FAIL single_pkt: starts=%0d level=%0d required 1/0", start_cnt - s0, fifo_rd_water_level);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int s0 = start_cnt;
    load_words(600);
    run_packet(256, 1'b1);
    run_packet(256, 1'b0);
    repeat (10) @(negedge rd_clk);
    check_cnt++;
    if (start_cnt - s0 != 2 || fifo_rd_water_level !== 11'd88 || busy !== 1'b0)
      $display("FAIL back_to_back: starts=%0d level=%0d busy=%b required 2/88/0",
               start_cnt - s0, fifo_rd_water_level, busy);
    else pass_cnt++;
  endtask

  task automatic test_underrun();
    int s0 = start_cnt;
    load_words(167);
    repeat (30) @(negedge rd_clk);
    check_cnt++;
    if (start_cnt != s0 || busy !== 1'b0)
      $display("FAIL level_255_no_start: starts=%0d busy=%b required 0/0", start_cnt - s0, busy);
    else pass_cnt++;
    force_lvl = 1'b1;
    forced_level = 256;
    wait_start(256);
    force_lvl = 1'b0;
    drain(256, 1'b0);
    finish_packet();
    check_cnt++;
    if (underrun !== 1'b1 || fifo_rd_water_level !== 11'd0)
      $display("FAIL underrun_sticky: underrun=%b level=%0d required 1/0", underrun, fifo_rd_water_level);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int r0, s0;
    load_words(256);
    wait_start(256);
    r0 = rden_cnt;
    for (int i = 0; i < 100; i++) begin
      tx_req = 1'b1;
      void'(model_q.pop_front());
      @(negedge rd_clk);
    end
    tx_req = 1'b0;
    rd_rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({fifo_rd_en, tx_start_en, tx_byte_num, tx_data, busy, underrun, pkt_cnt} !== 84'd0)
      $display("FAIL midreset_outputs: got %h required 0",
               {fifo_rd_en, tx_start_en, tx_byte_num, tx_data, busy, underrun, pkt_cnt});
    else pass_cnt++;
    check_cnt++;
    if (rden_cnt - r0 != 100) $display("FAIL midreset_reads: got %0d required 100", rden_cnt - r0);
    else pass_cnt++;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    exp_pkt = 0;
    exp_underrun = 1'b0;
    s0 = start_cnt;
    repeat (40) @(negedge rd_clk);
    check_cnt++;
    if (start_cnt != s0 || busy !== 1'b0 || underrun !== 1'b0 || fifo_rd_water_level !== 11'd156)
      $display("FAIL after_reset_idle: starts=%0d busy=%b underrun=%b level=%0d required 0/0/0/156",
               start_cnt - s0, busy, underrun, fifo_rd_water_level);
    else pass_cnt++;
    load_words(100);
    run_packet(256, 1'b1);
  endtask

  task automatic test_timeout();
    int t = 0;
    int s0 = start_cnt;
    load_words(10);
`ifdef UDP_TX_TIMEOUT_FLUSH_EN
    while (tx_start_en !== 1'b1 && t < 400) begin
      @(negedge rd_clk);
      t++;
    end
    check_cnt++;
    if (t < TIMEOUT_CYCLES || t > TIMEOUT_CYCLES + 2)
      $display("FAIL flush_delay: got %0d cycles required %0d..%0d", t, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 2);
    else pass_cnt++;
    run_packet(10, 1'b0);
    check_cnt++;
    if (start_cnt - s0 != 1 || fifo_rd_water_level !== 11'd0)
      $display("FAIL flush_pkt: starts=%0d level=%0d required 1/0", start_cnt - s0, fifo_rd_water_level);
    else pass_cnt++;
`else
    while (t < 300) begin
      @(negedge rd_clk);
      t++;
    end
    check_cnt++;
    if (start_cnt != s0 || busy !== 1'b0 || fifo_rd_water_level !== 11'd10)
      $display("FAIL no_flush: starts=%0d busy=%b level=%0d required 0/0/10",
               start_cnt - s0, busy, fifo_rd_water_level);
    else pass_cnt++;
`endif
  endtask

  initial begin
    @(negedge rd_clk);
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_underrun();
    test_mid_reset();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
